// File: rtl/power_pkg.sv
// Shared types and constants for the square/cube power unit.
// Provides the FSM state type, default width and counter-width helper.
package power_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQ   = 2'd1,
      CU   = 2'd2
   } state_t;

   localparam int WIDTH_DEF = 16;
   localparam int CNT_W     = $clog2(WIDTH_DEF);

   // Step-counter width for a given operand width (never below 1 bit).
   function automatic int cnt_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/square_cube_power_shift_add_step.sv
// One shift-add multiply step with its accumulator register.
// Ports: clk, rst_n, clr, en, add (multiplier bit), mcand, shift, acc_sum.
module shift_add_step #(
   parameter int MW = 32,
   parameter int AW = 48,
   parameter int SW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   input  logic          add,
   input  logic [MW-1:0] mcand,
   input  logic [SW-1:0] shift,
   output logic [AW-1:0] acc_sum
);

   logic [AW-1:0] acc;
   logic [AW-1:0] addend;

   assign addend  = add ? ({{(AW-MW){1'b0}}, mcand} << shift) : '0;
   // Exposed so the owner can capture a finished product on the same
   // edge that clears the accumulator for the next pass.
   assign acc_sum = acc + addend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   acc <= '0;
      else if (clr) acc <= '0;
      else if (en)  acc <= acc_sum;
   end

endmodule

// File: rtl/square_cube_power.sv
// Sequential square/cube unit: two shift-add passes on one datapath.
// Ports: clk, rst_n, start, number -> busy, done, square, cube.
module square_cube_power
   import power_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   number,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] square,
   output logic [3*WIDTH-1:0] cube
);

   localparam int CW = cnt_w(WIDTH);
   localparam int AW = 3 * WIDTH;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   n;
   logic [2*WIDTH-1:0] sq_r;
   logic [2*WIDTH-1:0] mcand;
   logic [AW-1:0]      acc_sum;
   logic               last;
   logic               acc_clr;
   logic               acc_en;

   assign last    = (cnt == CW'(WIDTH - 1));
   // Clear on accept, and at the end of SQ so CU starts from zero.
   assign acc_clr = ((state == IDLE) && start) ||
                    ((state == SQ) && last);
   assign acc_en  = (state != IDLE);
   assign mcand   = (state == CU) ? sq_r : {{WIDTH{1'b0}}, n};

   shift_add_step #(
      .MW (2*WIDTH),
      .AW (AW),
      .SW (CW)
   ) u_step (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (acc_clr),
      .en      (acc_en),
      .add     (n[cnt]),
      .mcand   (mcand),
      .shift   (cnt),
      .acc_sum (acc_sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         n      <= '0;
         sq_r   <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         square <= '0;
         cube   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  n     <= number;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SQ;
               end
            end
            SQ: begin
               if (last) begin
                  sq_r  <= acc_sum[2*WIDTH-1:0];
                  cnt   <= '0;
                  state <= CU;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            CU: begin
               if (last) begin
                  square <= sq_r;
                  cube   <= acc_sum;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  cnt    <= '0;
                  state  <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
